// File: rtl/bcd_key_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_key_pkg
//  Description : Shared types and constants for the BCD key counter slice.
//                - deb_state_t : key debounce FSM state encoding
//                - bcd_digit_t : one 8421 BCD digit
//                - BCD_MAX_DIGIT : largest legal BCD digit value
//  Revision    : 1.0  initial release
// ============================================================================
package bcd_key_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } deb_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

endpackage : bcd_key_pkg
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Synchronises a raw push-button and debounces it with a
//                four-state FSM. Emits a one-cycle step pulse on every
//                accepted press (and, with autorepeat, while held).
//  Macro       : BCD_KEY_AUTOREPEAT_EN adds REP_DELAY / REP_PERIOD and the
//                held-key repeat timer.
//  Ports       : clk     - clock
//                rst_n   - asynchronous active-low reset
//                i_key   - raw asynchronous key (1 = pressed)
//                o_step  - one-cycle step request
//  Revision    : 1.0  initial release
// ============================================================================
module key_debounce
    import bcd_key_pkg::*;
#(
    parameter int DEB_CYCLES = 4
`ifdef BCD_KEY_AUTOREPEAT_EN
    ,
    parameter int REP_DELAY  = 500,
    parameter int REP_PERIOD = 100
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key,
    output logic o_step
);

    localparam int c_dcnt_w = $clog2(DEB_CYCLES);
    localparam logic [c_dcnt_w-1:0] c_deb_last = c_dcnt_w'(DEB_CYCLES - 1);

    logic                r_key_meta;
    logic                r_key_s;
    deb_state_t          r_state;
    logic [c_dcnt_w-1:0] r_dcnt;
    logic                w_accept;

    // The accepting condition is decoded from registered state so that the
    // counter can load on the very edge where the FSM enters HELD.
    assign w_accept = (r_state == PRESS_WAIT) && r_key_s && (r_dcnt == c_deb_last);

    // Two-flop synchroniser; nothing else looks at i_key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_meta <= 1'b0;
            r_key_s    <= 1'b0;
        end else begin
            r_key_meta <= i_key;
            r_key_s    <= r_key_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_dcnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_key_s) begin
                        r_state <= PRESS_WAIT;
                        r_dcnt  <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!r_key_s) begin
                        r_state <= IDLE;
                    end else if (r_dcnt == c_deb_last) begin
                        r_state <= HELD;
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!r_key_s) begin
                        r_state <= REL_WAIT;
                        r_dcnt  <= '0;
                    end
                end
                REL_WAIT: begin
                    // A bounce back high during release is still the same
                    // press, so it returns to HELD without a new step.
                    if (r_key_s) begin
                        r_state <= HELD;
                    end else if (r_dcnt == c_deb_last) begin
                        r_state <= IDLE;
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_dcnt  <= '0;
                end
            endcase
        end
    end

`ifdef BCD_KEY_AUTOREPEAT_EN
    localparam int c_rep_max = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int c_rep_w   = $clog2(c_rep_max) + 1;
    localparam logic [c_rep_w-1:0] c_dly_last = c_rep_w'(REP_DELAY - 1);
    localparam logic [c_rep_w-1:0] c_per_last = c_rep_w'(REP_PERIOD - 1);

    logic [c_rep_w-1:0] r_rep_cnt;
    logic               r_rep_phase;   // 0: waiting initial delay, 1: periodic
    logic               w_held_stay;
    logic               w_rep_fire;

    // The timer only runs on cycles where the FSM remains in HELD, so any
    // (re)entry into HELD restarts the initial delay from zero.
    assign w_held_stay = (r_state == HELD) && r_key_s;
    assign w_rep_fire  = w_held_stay &&
                         (r_rep_cnt == (r_rep_phase ? c_per_last : c_dly_last));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
        end else if (!w_held_stay) begin
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
        end else if (w_rep_fire) begin
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b1;
        end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
        end
    end

    assign o_step = w_accept | w_rep_fire;
`else
    assign o_step = w_accept;
`endif

endmodule : key_debounce
`default_nettype wire

// File: rtl/bcd_key_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_key_counter
//  Description : Two-digit BCD up/down counter stepped by a debounced push
//                button. Count runs 0..MODULO-1 and is held natively in BCD.
//  Macro       : BCD_KEY_AUTOREPEAT_EN enables held-key autorepeat
//                (REP_DELAY / REP_PERIOD parameters).
//  Ports       : clk     - clock
//                rst_n   - asynchronous active-low reset
//                key     - raw bouncy push-button (1 = pressed)
//                dir     - 0 = count up, 1 = count down
//                clr     - synchronous clear of the count (beats a step)
//                bcd_lo  - units digit (0..9)
//                bcd_hi  - tens digit (0..9)
//                upd     - one-cycle pulse when the digits change
//                wrap    - one-cycle pulse on wrap-around
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_key_counter
    import bcd_key_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int MODULO     = 100
`ifdef BCD_KEY_AUTOREPEAT_EN
    ,
    parameter int REP_DELAY  = 500,
    parameter int REP_PERIOD = 100
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key,
    input  logic       dir,
    input  logic       clr,
    output logic [3:0] bcd_lo,
    output logic [3:0] bcd_hi,
    output logic       upd,
    output logic       wrap
);

    // Digits of the top count value MODULO-1.
    localparam bcd_digit_t c_max_hi = bcd_digit_t'((MODULO - 1) / 10);
    localparam bcd_digit_t c_max_lo = bcd_digit_t'((MODULO - 1) % 10);

    logic       w_step;
    logic       w_at_max;
    logic       w_at_zero;
    bcd_digit_t r_bcd_lo;
    bcd_digit_t r_bcd_hi;
    logic       r_upd;
    logic       r_wrap;

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
`ifdef BCD_KEY_AUTOREPEAT_EN
        ,
        .REP_DELAY  (REP_DELAY),
        .REP_PERIOD (REP_PERIOD)
`endif
    ) u_key_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_key  (key),
        .o_step (w_step)
    );

    assign w_at_max  = (r_bcd_hi == c_max_hi) && (r_bcd_lo == c_max_lo);
    assign w_at_zero = (r_bcd_hi == '0) && (r_bcd_lo == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd_lo <= '0;
            r_bcd_hi <= '0;
            r_upd    <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            r_upd  <= 1'b0;
            r_wrap <= 1'b0;
            if (clr) begin
                // Clear wins over a coincident step; the step is dropped.
                r_bcd_lo <= '0;
                r_bcd_hi <= '0;
                r_upd    <= !w_at_zero;
            end else if (w_step) begin
                r_upd <= 1'b1;
                if (!dir) begin
                    if (w_at_max) begin
                        r_bcd_lo <= '0;
                        r_bcd_hi <= '0;
                        r_wrap   <= 1'b1;
                    end else if (r_bcd_lo == BCD_MAX_DIGIT) begin
                        r_bcd_lo <= '0;
                        r_bcd_hi <= r_bcd_hi + 4'd1;
                    end else begin
                        r_bcd_lo <= r_bcd_lo + 4'd1;
                    end
                end else begin
                    if (w_at_zero) begin
                        r_bcd_lo <= c_max_lo;
                        r_bcd_hi <= c_max_hi;
                        r_wrap   <= 1'b1;
                    end else if (r_bcd_lo == '0) begin
                        r_bcd_lo <= BCD_MAX_DIGIT;
                        r_bcd_hi <= r_bcd_hi - 4'd1;
                    end else begin
                        r_bcd_lo <= r_bcd_lo - 4'd1;
                    end
                end
            end
        end
    end

    assign bcd_lo = r_bcd_lo;
    assign bcd_hi = r_bcd_hi;
    assign upd    = r_upd;
    assign wrap   = r_wrap;

endmodule : bcd_key_counter
`default_nettype wire
